// File: rtl/tomasulo_issue_unit.sv
// In-order issue stage: 4-entry instruction FIFO, tagged register file with CDB snoop and forwarding.
// Issue outputs are combinational from the FIFO head; a stalled head blocks all younger entries.
module tomasulo_issue_unit #(
    parameter int FIFO_DEPTH = 4,
    parameter int NREGS      = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    input  logic         i_instr_valid,
    output logic         o_instr_ready,
    input  logic [1:0]   i_instr_op,
    input  logic [3:0]   i_instr_rd,
    input  logic [3:0]   i_instr_rs1,
    input  logic [3:0]   i_instr_rs2,
    input  logic [3:0]   i_rs_ready,
    input  logic [31:0]  i_rs_acceptor_tag,
    output logic [3:0]   o_issue_valid,
    output logic [31:0]  o_src_out_1,
    output logic [31:0]  o_src_out_2,
    output logic         o_src_out1_type,
    output logic         o_src_out2_type,
    input  logic [127:0] i_cdb_data_serialized,
    input  logic [31:0]  i_cdb_tag_serialized
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
    } instr_t;

    instr_t        r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;
    logic [31:0]   r_val  [NREGS];
    logic [7:0]    r_tag  [NREGS];

    instr_t        w_head;
    logic [1:0]    w_sel;
    logic          w_issue;
    logic          w_push;
    logic [7:0]    w_acc_tag;
    logic [32:0]   w_op1;
    logic [32:0]   w_op2;
    logic          w_wb_hit  [NREGS];
    logic [31:0]   w_wb_data [NREGS];

    // Returns {type, data}; lanes are scanned high to low so the lowest matching lane wins.
    function automatic logic [32:0] f_operand(
        input logic [3:0]   rs,
        input logic [7:0]   tag,
        input logic [31:0]  val,
        input logic [31:0]  cdb_tag,
        input logic [127:0] cdb_data
    );
        logic [32:0] res;
        if (rs == 4'd0) begin
            res = '0;
        end else if (!tag[7]) begin
            res = {1'b0, val};
        end else begin
            res = {1'b1, 24'b0, tag};
            for (int l = 3; l >= 0; l--) begin
                if (cdb_tag[31-8*l -: 8] == tag) begin
                    res = {1'b0, cdb_data[127-32*l -: 32]};
                end
            end
        end
        return res;
    endfunction

    // Unit type 0..3 maps to rs_ready / acceptor byte index 3..0.
    assign w_head        = r_fifo[r_head];
    assign w_sel         = ~w_head.op;
    assign o_instr_ready = (r_count != (PW+1)'(FIFO_DEPTH));
    assign w_issue       = (r_count != '0) && i_en && i_rs_ready[w_sel];
    assign w_push        = i_instr_valid && o_instr_ready && i_en;
    assign w_acc_tag     = i_rs_acceptor_tag[{w_sel, 3'b000} +: 8];
    assign o_issue_valid = w_issue ? (4'b0001 << w_sel) : 4'b0000;

    always_comb begin
        w_op1 = '0;
        w_op2 = '0;
        if (w_issue) begin
            w_op1 = f_operand(w_head.rs1, r_tag[w_head.rs1], r_val[w_head.rs1],
                              i_cdb_tag_serialized, i_cdb_data_serialized);
            w_op2 = f_operand(w_head.rs2, r_tag[w_head.rs2], r_val[w_head.rs2],
                              i_cdb_tag_serialized, i_cdb_data_serialized);
        end
    end

    assign {o_src_out1_type, o_src_out_1} = w_op1;
    assign {o_src_out2_type, o_src_out_2} = w_op2;

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            w_wb_hit[r]  = 1'b0;
            w_wb_data[r] = '0;
            if (r_tag[r][7]) begin
                for (int l = 3; l >= 0; l--) begin
                    if (i_cdb_tag_serialized[31-8*l -: 8] == r_tag[r]) begin
                        w_wb_hit[r]  = 1'b1;
                        w_wb_data[r] = i_cdb_data_serialized[127-32*l -: 32];
                    end
                end
            end
        end
    end

    // A rename of rd takes priority over a same-cycle retirement of its old tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                r_val[r] <= '0;
                r_tag[r] <= '0;
            end
        end else if (i_en) begin
            for (int r = 1; r < NREGS; r++) begin
                if (w_issue && (int'(w_head.rd) == r)) begin
                    r_tag[r] <= w_acc_tag;
                end else if (w_wb_hit[r]) begin
                    r_val[r] <= w_wb_data[r];
                    r_tag[r] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_tail] <= {i_instr_op, i_instr_rd, i_instr_rs1, i_instr_rs2};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_issue) begin
                r_head <= r_head + PW'(1);
            end
            r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_issue);
        end
    end
endmodule

// File: tb/tb_tomasulo_issue_unit.sv
// Bench for tomasulo_issue_unit: queue/array reference model, directed scenarios, then random traffic.
module tb_tomasulo_issue_unit;
    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         instr_valid;
    logic         instr_ready;
    logic [1:0]   op;
    logic [3:0]   rd, rs1, rs2;
    logic [3:0]   rs_ready;
    logic [31:0]  acc;
    logic [3:0]   issue_valid;
    logic [31:0]  src1, src2;
    logic         t1, t2;
    logic [127:0] cdb_data;
    logic [31:0]  cdb_tag;

    tomasulo_issue_unit #(.FIFO_DEPTH(4), .NREGS(16)) dut (
        .clk(clk), .reset(reset), .i_en(en),
        .i_instr_valid(instr_valid), .o_instr_ready(instr_ready),
        .i_instr_op(op), .i_instr_rd(rd), .i_instr_rs1(rs1), .i_instr_rs2(rs2),
        .i_rs_ready(rs_ready), .i_rs_acceptor_tag(acc),
        .o_issue_valid(issue_valid), .o_src_out_1(src1), .o_src_out_2(src2),
        .o_src_out1_type(t1), .o_src_out2_type(t2),
        .i_cdb_data_serialized(cdb_data), .i_cdb_tag_serialized(cdb_tag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
    } ins_t;

    ins_t        mq[$];
    logic [31:0] m_val [16];
    logic [7:0]  m_tag [16];
    logic        m_init = 1'b0;
    logic        e_issue;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lane_tag(input int l);
        return cdb_tag[31-8*l -: 8];
    endfunction

    function automatic logic [31:0] lane_data(input int l);
        return cdb_data[127-32*l -: 32];
    endfunction

    // {type, data} for a source register under the current model state and CDB.
    function automatic logic [32:0] resolve(input logic [3:0] rs);
        if (rs == 4'd0) return 33'd0;
        if (!m_tag[rs][7]) return {1'b0, m_val[rs]};
        for (int l = 0; l < 4; l++)
            if (lane_tag(l) == m_tag[rs]) return {1'b0, lane_data(l)};
        return {1'b1, 24'b0, m_tag[rs]};
    endfunction

    task automatic settle();
        logic [32:0] o1, o2;
        logic [3:0]  e_iv;
        #1;
        e_issue = 1'b0;
        e_iv = 4'b0;
        o1 = '0;
        o2 = '0;
        if (mq.size() != 0) begin
            e_issue = en && rs_ready[3 - mq[0].op];
            if (e_issue) begin
                e_iv[3 - mq[0].op] = 1'b1;
                o1 = resolve(mq[0].rs1);
                o2 = resolve(mq[0].rs2);
            end
        end
        if (m_init) begin
            chk("instr_ready", 32'(instr_ready), 32'(mq.size() != 4));
            chk("issue_valid", 32'(issue_valid), 32'(e_iv));
            chk("src_out_1", src1, o1[31:0]);
            chk("src_out_2", src2, o2[31:0]);
            chk("src_out1_type", 32'(t1), 32'(o1[32]));
            chk("src_out2_type", 32'(t2), 32'(o2[32]));
        end
    endtask

    task automatic advance();
        logic [31:0] nv [16];
        logic [7:0]  nt [16];
        logic        push;
        logic        found;
        if (reset) begin
            mq.delete();
            for (int r = 0; r < 16; r++) begin
                m_val[r] = '0;
                m_tag[r] = '0;
            end
            m_init = 1'b1;
        end else if (en) begin
            push = instr_valid && (mq.size() != 4);
            nv = m_val;
            nt = m_tag;
            for (int r = 1; r < 16; r++) begin
                found = 1'b0;
                if (m_tag[r][7]) begin
                    for (int l = 0; l < 4; l++) begin
                        if (!found && lane_tag(l) == m_tag[r]) begin
                            nv[r] = lane_data(l);
                            nt[r] = 8'h00;
                            found = 1'b1;
                        end
                    end
                end
            end
            if (e_issue) begin
                if (mq[0].rd != 4'd0) begin
                    nt[mq[0].rd] = acc[8*(3 - mq[0].op) +: 8];
                    nv[mq[0].rd] = m_val[mq[0].rd];
                end
                void'(mq.pop_front());
            end
            if (push) mq.push_back({op, rd, rs1, rs2});
            m_val = nv;
            m_tag = nt;
        end
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic put(input logic [1:0] o, input logic [3:0] d, input logic [3:0] a, input logic [3:0] b);
        instr_valid = 1'b1;
        op = o; rd = d; rs1 = a; rs2 = b;
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; instr_valid = 1'b0;
        op = '0; rd = '0; rs1 = '0; rs2 = '0;
        rs_ready = '0; acc = '0; cdb_data = '0; cdb_tag = '0;
        @(negedge clk);
        step();
        step();
        reset = 1'b0;

        // add r3 = r1 + r2, add acceptor tag 0xC2
        rs_ready = 4'b0100; acc = 32'h00C2_0000;
        put(2'd1, 4'd3, 4'd1, 4'd2);
        settle(); chk("lit_first_no_issue", 32'(issue_valid), 32'h0); chk("lit_ready_reset", 32'(instr_ready), 32'h1); advance();
        instr_valid = 1'b0;
        settle(); chk("lit_add_issue", 32'(issue_valid), 32'h4); chk("lit_add_src1", src1, 32'h0);
        chk("lit_add_t1", 32'(t1), 32'h0); advance();

        // add r4 = r3 + r3 while r3 pending 0xC2
        acc = 32'h00C3_0000; put(2'd1, 4'd4, 4'd3, 4'd3); step();
        instr_valid = 1'b0;
        settle(); chk("lit_pend_src1", src1, 32'h0000_00C2); chk("lit_pend_src2", src2, 32'h0000_00C2);
        chk("lit_pend_t1", 32'(t1), 32'h1); chk("lit_pend_t2", 32'(t2), 32'h1); advance();

        // add r5 = r3 + r3 with lane2 retiring 0xC2 in the issue cycle
        acc = 32'h0091_0000; put(2'd1, 4'd5, 4'd3, 4'd3); step();
        instr_valid = 1'b0; cdb_tag = 32'h0000_C200; cdb_data = 128'h1234 << 32;
        settle(); chk("lit_fwd_src1", src1, 32'h1234); chk("lit_fwd_src2", src2, 32'h1234);
        chk("lit_fwd_t2", 32'(t2), 32'h0); advance();
        cdb_tag = '0; cdb_data = '0;
        acc = 32'h00B0_0000; put(2'd1, 4'd6, 4'd3, 4'd0); step();
        instr_valid = 1'b0;
        settle(); chk("lit_wb_src1", src1, 32'h1234); chk("lit_wb_t1", 32'(t1), 32'h0); advance();

        // rename r5 -> 0xA1 while lane0 retires its old tag 0x91
        acc = 32'h00A1_0000; put(2'd1, 4'd5, 4'd0, 4'd0); step();
        instr_valid = 1'b0; cdb_tag = 32'h9100_0000; cdb_data = {32'h0000_DEAD, 96'h0};
        step();
        cdb_tag = '0; cdb_data = '0;
        acc = 32'h00A2_0000; put(2'd1, 4'd7, 4'd5, 4'd5); step();
        instr_valid = 1'b0;
        settle(); chk("lit_rename_src1", src1, 32'h0000_00A1); chk("lit_rename_t1", 32'(t1), 32'h1); advance();

        // stall a div head, fill the FIFO, then release in order
        rs_ready = 4'b0000; acc = 32'h8C8B_8A89;
        for (int i = 0; i < 4; i++) begin
            put(2'(3 - i), 4'(8 + i), 4'd1, 4'd2);
            settle(); chk("lit_stall_no_issue", 32'(issue_valid), 32'h0); advance();
        end
        put(2'd1, 4'd13, 4'd0, 4'd0);
        settle(); chk("lit_full_ready", 32'(instr_ready), 32'h0); chk("lit_full_no_issue", 32'(issue_valid), 32'h0); advance();
        instr_valid = 1'b0; rs_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            settle(); chk("lit_order", 32'(issue_valid), 32'(4'b0001 << i)); advance();
        end

        // reset with three buffered entries and pending tags
        rs_ready = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            put(2'd1, 4'(12 + i), 4'd4, 4'd7); step();
        end
        instr_valid = 1'b0; reset = 1'b1; step();
        reset = 1'b0; rs_ready = 4'b1111;
        settle(); chk("lit_rst_ready", 32'(instr_ready), 32'h1); chk("lit_rst_no_issue", 32'(issue_valid), 32'h0); advance();
        acc = 32'h00C4_0000; put(2'd1, 4'd12, 4'd4, 4'd7); step();
        instr_valid = 1'b0;
        settle(); chk("lit_rst_src1", src1, 32'h0); chk("lit_rst_t2", 32'(t2), 32'h0); advance();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            en = ($urandom_range(0, 9) != 0);
            instr_valid = ($urandom_range(0, 9) < 6);
            op = 2'($urandom); rd = 4'($urandom); rs1 = 4'($urandom); rs2 = 4'($urandom);
            for (int b = 0; b < 4; b++) begin
                rs_ready[b] = ($urandom_range(0, 9) < 7);
                acc[8*b +: 8] = {($urandom_range(0, 9) != 0), 7'($urandom)};
                cdb_data[32*b +: 32] = $urandom;
                if ($urandom_range(0, 1) == 0)
                    cdb_tag[8*b +: 8] = m_tag[$urandom_range(0, 15)];
                else
                    cdb_tag[8*b +: 8] = 8'($urandom);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tomasulo_issue_unit.md
# tomasulo_issue_unit

In-order issue stage that sits directly upstream of the addition/multiply/divide/memory reservation stations. It buffers decoded instructions in a 4-entry FIFO and reads operands from a 16-entry tagged register file. It dispatches the FIFO head to the reservation station of matching type when that station reports a free slot, delivering each operand as either data or a producer tag. It snoops the 4-lane CDB to retire tags into the register file, and forwards same-cycle CDB results into issued operands.

## Interface
Parameters:
- FIFO_DEPTH, 4: instruction buffer entries (power of two).
- NREGS, 16: architectural registers; r0 reads as zero and is never renamed.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- en  in  1  global enable; when low, all state holds and issue_valid is 0.
- instr_valid  in  1  decoder offers an instruction.
- instr_ready  out  1  FIFO not full; a transfer occurs when valid && ready at posedge.
- instr_op  in  2  unit type: 0 mem, 1 add, 2 mul, 3 div.
- instr_rd, instr_rs1, instr_rs2  in  4 each  register indices.
- rs_ready  in  4  per-type free-slot flag, bit order {mem, add, mul, div} = bits [3:0].
- rs_acceptor_tag  in  32  serialized {mem, add, mul, div} 8-bit tags, mem in [31:24]; tag format {valid, mem, add, mul, div, id[2:0]}.
- issue_valid  out  4  one-hot src_in_valid per type, same bit order as rs_ready.
- src_out_1, src_out_2  out  32 each  operand data, or tag in [7:0] with upper bits zero.
- src_out1_type, src_out2_type  out  1 each  0 data, 1 tag.
- CDB_data_serialized  in  128  lane0 in [127:96].
- CDB_tag_serialized  in  32  lane0 in [31:24].

## Operation
- Register file: per register a 32-bit value and an 8-bit tag. A tag with bit 7 set means pending.
- Tag match: the two 8-bit values are equal and bit 7 is set.
- FIFO: registered head/tail pointers and a count. instr_ready = (count != FIFO_DEPTH). Push and pop in the same cycle are allowed and leave count unchanged. A push when full is impossible because instr_ready is 0.
- Issue condition: count != 0 && en && rs_ready[type(head)]. When it holds:
  - issue_valid has exactly that bit set.
  - The head is popped at the posedge.
  - If rd != 0, rd.tag takes the selected rs_acceptor_tag byte.
- Operand read for rsN:
  - r0 gives data 0, type 0.
  - A register with a non-pending tag gives its value, type 0.
  - A pending register whose tag matches a CDB lane this cycle gives that lane's data, type 0. The lowest-numbered matching lane wins.
  - Otherwise the output is {24'b0, tag}, type 1.
- Writeback: every register whose pending tag matches a lane this cycle takes that lane's data, and its tag is cleared to 0.
- Simultaneous writeback and rename of the same rd: the rename wins, so the tag becomes the new acceptor tag and the value is not updated.
- rs1 == rs2: both operands resolve identically.
- rd == rs1/rs2 on the issuing instruction: operands use the pre-rename state.
- No issue, or en low: issue_valid = 0, src outputs = 0, types = 0.
- Reset: FIFO empty, all values 0, all tags 0; instr_ready = 1, issue_valid = 0. Reset in mid-operation discards all buffered instructions and pending tags.

## Timing
- All issue outputs are combinational from the FIFO head, register state, rs_ready and the CDB. The reservation station samples them at the same posedge that pops the FIFO.
- Minimum latency instr_valid→issue is 1 cycle, because the entry must be registered first; there is no FIFO bypass.
- Throughput: 1 issue per cycle.
- Issue is in order: a stalled head (its rs_ready is 0) blocks every younger entry.
- A CDB result is visible in the register file the cycle after the broadcast. In the broadcast cycle it is delivered through forwarding.

## Test plan
- Reset, then push add r3=r1+r2 with rs_ready=4'b0100 and add tag 0xC2 → next cycle issue_valid=4'b0100, src types 0, data 0/0; afterwards r3.tag=0xC2.
- Push add r4=r3+r3 while r3 is pending 0xC2 with no CDB activity → src_out_1=src_out_2=0x000000C2, both types 1.
- Same instruction, but CDB lane2 carries tag 0xC2 with data 0x1234 in the issue cycle → both operands data 0x1234 type 0; r3 reads 0x1234 afterwards.
- Rename of r5 to 0xA1 in the same cycle that lane0 retires r5's old tag 0x91 → r5.tag=0xA1 and the value is unchanged.
- Hold rs_ready[div]=0 with the head being div, then push 4 more → instr_ready drops at count=4, no issue occurs; raising rs_ready issues in program order.
- Assert reset with 3 buffered entries and pending tags → count 0, all tags 0, issue_valid 0 on the next cycle.
